// File: rtl/sprite_arb_pkg.sv
// sprite_arb_pkg: shared widths, default parameters and FSM states for the sprite ROM arbiter
package sprite_arb_pkg;
  localparam int ROM_AW          = 8;
  localparam int ROM_DW          = 16;
  localparam int DEF_NUM_REQ     = 3;
  localparam int DEF_ROM_LATENCY = 2;
  localparam int DEF_BURST_W     = 4;
  typedef enum logic {IDLE, BURST} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after the previous winner
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_winner,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] c;
  // scan farthest-to-nearest so the requester closest after last_winner overrides the rest
  always_comb begin
    idx = '0;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = IW'((int'(last_winner) + k) % N);
      if (req[c]) idx = c;
    end
    gnt = '0;
    gnt[idx] = |req;
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin burst reader sharing one registered sprite ROM between reel renderers
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ROM_LATENCY = DEF_ROM_LATENCY,
  parameter int BURST_W     = DEF_BURST_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ROM_AW-1:0]  base_addr,
  input  logic [NUM_REQ*BURST_W-1:0] burst_len,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [ROM_AW-1:0]          rom_addr,
  input  logic [ROM_DW-1:0]          rom_dout,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [ROM_DW-1:0]          rsp_data,
  output logic                       rsp_last,
  output logic                       busy
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state, state_nxt;
  logic [IW-1:0] last_winner, cur_id, win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic [BURST_W-1:0] cnt;
  logic [ROM_LATENCY-1:0] pv, plast;
  logic [IW-1:0] pid [ROM_LATENCY];
  logic start;
  assign start = state == IDLE && |req;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(req),
    .last_winner(last_winner),
    .gnt(win_gnt),
    .idx(win_idx)
  );
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  // a burst starts from IDLE on any request and ends after its final address cycle
  always_comb state_nxt = state == IDLE ? (|req ? BURST : IDLE) : (cnt == '0 ? IDLE : BURST);
  // grant capture, beat countdown and address walk; address holds while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_winner <= IW'(NUM_REQ - 1);
      cur_id <= '0;
      cnt <= '0;
      gnt <= '0;
      rom_addr <= '0;
    end else begin
      gnt <= start ? win_gnt : '0;
      if (start) begin
        last_winner <= win_idx;
        cur_id <= win_idx;
        cnt <= burst_len[win_idx*BURST_W +: BURST_W];
        rom_addr <= base_addr[win_idx*ROM_AW +: ROM_AW];
      end else if (state == BURST && cnt != '0) begin
        cnt <= cnt - 1'b1;
        rom_addr <= rom_addr + ROM_AW'(1);
      end
    end
  end
  // tag pipeline tracking each address cycle until its ROM word emerges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
      plast <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) pid[i] <= '0;
    end else begin
      pv[0] <= state == BURST;
      plast[0] <= cnt == '0;
      pid[0] <= cur_id;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        plast[i] <= plast[i-1];
        pid[i] <= pid[i-1];
      end
    end
  end
  // response outputs are zeroed whenever no tag is at the pipeline end
  always_comb begin
    busy = state == BURST || |pv;
    rsp_valid = pv[ROM_LATENCY-1];
    rsp_id = rsp_valid ? pid[ROM_LATENCY-1] : '0;
    rsp_last = rsp_valid & plast[ROM_LATENCY-1];
    rsp_data = rsp_valid ? rom_dout : '0;
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed and random bursts checked against a schedule-based reference model
module tb_sprite_rom_arbiter;
  localparam int N = 3, L = 2, BW = 4, IW = $clog2(N), R = 64;
  logic clk = 0, reset = 1;
  logic [N-1:0] req = '0;
  logic [N*8-1:0] base_addr = '0;
  logic [N*BW-1:0] burst_len = '0;
  logic [N-1:0] gnt;
  logic [7:0] rom_addr;
  logic [15:0] rom_dout, rsp_data, s1, s2;
  logic rsp_valid, rsp_last, busy;
  logic [IW-1:0] rsp_id;
  logic [15:0] img [256];
  int total = 0, bad = 0;
  int cyc, next_arb, lw;
  bit auto_drop;
  logic [7:0] last_addr;
  logic [N-1:0] e_gnt [R];
  bit e_av [R], e_rv [R], e_rl [R], e_busy [R];
  logic [7:0] e_a [R];
  int e_rid [R];
  logic [15:0] e_rd [R];

  always #5 clk = ~clk;
  always @(posedge clk) begin
    s1 <= img[rom_addr];
    s2 <= s1;
  end
  assign rom_dout = s2;

  sprite_rom_arbiter #(.NUM_REQ(N), .ROM_LATENCY(L), .BURST_W(BW)) dut (
    .clk(clk), .reset(reset), .req(req), .base_addr(base_addr), .burst_len(burst_len),
    .gnt(gnt), .rom_addr(rom_addr), .rom_dout(rom_dout), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < R; r++) begin
      e_gnt[r] = '0; e_av[r] = 0; e_a[r] = '0; e_rv[r] = 0;
      e_rid[r] = 0; e_rl[r] = 0; e_rd[r] = '0; e_busy[r] = 0;
    end
    cyc = 0; next_arb = 0; lw = N - 1; last_addr = '0;
  endtask

  task automatic set_src(input int i, input logic [7:0] b, input logic [BW-1:0] l);
    base_addr[i*8 +: 8] = b;
    burst_len[i*BW +: BW] = l;
  endtask

  // one clock: the model plans a whole burst when it grants, then every output is compared
  task automatic step();
    int w, n, c, r;
    logic [7:0] b, a;
    logic [N-1:0] g;
    @(posedge clk);
    cyc++;
    if (cyc >= next_arb && |req) begin
      w = -1;
      for (int k = 1; k <= N; k++) if (w < 0 && req[(lw + k) % N]) w = (lw + k) % N;
      lw = w;
      b = base_addr[w*8 +: 8];
      n = int'(burst_len[w*BW +: BW]);
      e_gnt[cyc % R][w] = 1'b1;
      for (int i = 0; i <= n; i++) begin
        a = b + 8'(i);
        c = (cyc + i) % R;
        e_av[c] = 1; e_a[c] = a;
        c = (cyc + i + L) % R;
        e_rv[c] = 1; e_rid[c] = w; e_rl[c] = (i == n); e_rd[c] = img[a];
      end
      for (int i = 0; i <= n + L; i++) e_busy[(cyc + i) % R] = 1;
      next_arb = cyc + n + 2;
    end
    @(negedge clk);
    r = cyc % R;
    if (e_av[r]) last_addr = e_a[r];
    chk("gnt", 32'(gnt), 32'(e_gnt[r]));
    chk("rom_addr", 32'(rom_addr), 32'(last_addr));
    chk("busy", 32'(busy), 32'(e_busy[r]));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv[r]));
    if (e_rv[r]) begin
      chk("rsp_id", 32'(rsp_id), 32'(e_rid[r]));
      chk("rsp_last", 32'(rsp_last), 32'(e_rl[r]));
      chk("rsp_data", 32'(rsp_data), 32'(e_rd[r]));
    end
    g = e_gnt[r];
    e_gnt[r] = '0; e_av[r] = 0; e_rv[r] = 0; e_rl[r] = 0; e_busy[r] = 0;
    if (auto_drop) req = req & ~g;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
    chk({tag, "_rsp_last"}, 32'(rsp_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    reset = 1;
    req = '0;
    #1;
    check_zero("reset");
    clear_model();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) img[i] = 16'($urandom);
    clear_model();
    auto_drop = 1;
    repeat (2) @(negedge clk);
    check_zero("por");
    reset = 0;
    run(3);
    // single requester burst of four from 0x10
    set_src(0, 8'h10, 4'd3);
    req = 3'b001;
    run(10);
    // all three held with single-beat bursts: strict rotation 0,1,2,0 with an idle gap
    set_src(0, 8'h30, 4'd0); set_src(1, 8'h50, 4'd0); set_src(2, 8'h70, 4'd0);
    auto_drop = 0;
    req = 3'b111;
    run(12);
    req = '0;
    auto_drop = 1;
    run(6);
    // address wrap across 0xFF
    set_src(1, 8'hFE, 4'd3);
    req = 3'b010;
    run(10);
    // late request during a full-length burst, plus input changes that must be ignored
    set_src(0, 8'h80, 4'd15);
    req = 3'b001;
    run(4);
    set_src(2, 8'h20, 4'd1);
    req[2] = 1'b1;
    set_src(0, 8'hC0, 4'd2);
    run(30);
    // reset on the third beat flushes everything; requester 0 regains first priority
    set_src(0, 8'h40, 4'd15);
    req = 3'b001;
    run(3);
    do_reset();
    set_src(0, 8'h05, 4'd1); set_src(1, 8'h15, 4'd1); set_src(2, 8'h25, 4'd1);
    req = 3'b111;
    step();
    chk("gnt_after_reset", 32'(gnt), 32'h1);
    run(20);
    // winner drops its request right after the grant: all eight beats still issued
    set_src(0, 8'h60, 4'd7);
    req = 3'b001;
    run(14);
    // random traffic with sticky requests and free-running input changes
    for (int t = 0; t < 500; t++) begin
      if ($urandom_range(0, 3) == 0) req = req | N'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) set_src(i, 8'($urandom), BW'($urandom));
      step();
    end
    req = '0;
    run(25);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
